// File: rtl/parallel_to_serial.sv
// parallel_to_serial: LSB-first word serializer with valid/ready handshakes and a one-word holding register
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             serial_data,
  output logic             serial_last
);
  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_cnt = cw'(width - 1);
  logic [width-1:0] sh_q, sh_d, hold_q, hold_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic sh_valid_q, sh_valid_d, hold_valid_q, hold_valid_d;
  logic accept, bit_done, last_done, reload, load, shift_en, to_hold;
  assign parallel_ready = !hold_valid_q & !rst;
  assign serial_valid = sh_valid_q;
  assign serial_data = sh_q[0];
  assign serial_last = sh_valid_q & (cnt_q == last_cnt);
  always_comb begin
    accept = parallel_valid & parallel_ready;
    bit_done = sh_valid_q & serial_ready;
    last_done = bit_done & (cnt_q == last_cnt);
    reload = !sh_valid_q | last_done;
    load = reload & (hold_valid_q | accept);
    shift_en = bit_done & !last_done;
    to_hold = accept & !reload;
    sh_d = load ? (hold_valid_q ? hold_q : parallel_data) : shift_en ? {1'b0, sh_q[width-1:1]} : sh_q;
    cnt_d = load ? '0 : shift_en ? cnt_q + 1'b1 : cnt_q;
    sh_valid_d = load | (sh_valid_q & !last_done);
    hold_d = to_hold ? parallel_data : hold_q;
    hold_valid_d = to_hold | (hold_valid_q & !reload);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      sh_valid_q <= 1'b0;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      sh_valid_q <= sh_valid_d;
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: directed and random checks of parallel_to_serial with a loopback word rebuilder
module tb_parallel_to_serial;
  logic clk, rst;
  logic pv8, pr8, sv8, sr8, sd8, sl8;
  logic [7:0] pd8;
  logic pv5, pr5, sv5, sr5, sd5, sl5;
  logic [4:0] pd5;
  int total, passed;
  logic [7:0] exp8[$];
  logic [4:0] exp5[$];
  int k8, k5, rx8, rx5;
  logic [7:0] acc8;
  logic [4:0] acc5;
  logic pst8, psd8, psl8, pst5, psd5, psl5;
  parallel_to_serial #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .parallel_valid(pv8), .parallel_ready(pr8), .parallel_data(pd8),
    .serial_valid(sv8), .serial_ready(sr8), .serial_data(sd8), .serial_last(sl8)
  );
  parallel_to_serial #(.width(5)) dut5 (
    .clk(clk), .rst(rst), .parallel_valid(pv5), .parallel_ready(pr5), .parallel_data(pd5),
    .serial_valid(sv5), .serial_ready(sr5), .serial_data(sd5), .serial_last(sl5)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    if (rst) begin
      exp8.delete();
      k8 = 0;
      pst8 = 1'b0;
    end else begin
      if (pv8 && pr8) exp8.push_back(pd8);
      if (pst8) begin
        chk("stall8_data", sd8, psd8);
        chk("stall8_last", sl8, psl8);
      end
      pst8 = sv8 && !sr8;
      psd8 = sd8;
      psl8 = sl8;
      if (sv8 && sr8) begin
        acc8[k8] = sd8;
        chk("last8", sl8, k8 == 7);
        if (k8 == 7) begin
          chk("queue8", exp8.size() > 0, 1);
          if (exp8.size() > 0) chk("word8", acc8, exp8.pop_front());
          rx8++;
          k8 = 0;
        end else k8++;
      end
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      exp5.delete();
      k5 = 0;
      pst5 = 1'b0;
    end else begin
      if (pv5 && pr5) exp5.push_back(pd5);
      if (pst5) begin
        chk("stall5_data", sd5, psd5);
        chk("stall5_last", sl5, psl5);
      end
      pst5 = sv5 && !sr5;
      psd5 = sd5;
      psl5 = sl5;
      if (sv5 && sr5) begin
        acc5[k5] = sd5;
        chk("last5", sl5, k5 == 4);
        if (k5 == 4) begin
          chk("queue5", exp5.size() > 0, 1);
          if (exp5.size() > 0) chk("word5", acc5, exp5.pop_front());
          rx5++;
          k5 = 0;
        end else k5++;
      end
    end
  end
  initial begin
    logic [7:0] w, w2;
    logic [7:0] arr[3];
    int idx, run, maxrun, sawlow, r0, r5, c, b, a8, a5, cyc;
    logic a;
    total = 0;
    passed = 0;
    rx8 = 0;
    rx5 = 0;
    rst = 1'b1;
    pv8 = 1'b0; pd8 = '0; sr8 = 1'b1;
    pv5 = 1'b0; pd5 = '0; sr5 = 1'b1;
    repeat (2) step;
    chk("rst_valid", sv8, 0);
    chk("rst_data", sd8, 0);
    chk("rst_last", sl8, 0);
    chk("rst_ready", pr8, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", pr8, 1);
    w = 8'hA5;
    pd8 = w; pv8 = 1'b1;
    step;
    pv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", sv8, 1);
      chk("t1_bit", sd8, w[i]);
      chk("t1_last", sl8, i == 7);
      step;
    end
    chk("t1_idle", sv8, 0);
    arr[0] = 8'hA5; arr[1] = 8'h3C; arr[2] = 8'hFF;
    idx = 0; run = 0; maxrun = 0; sawlow = 0; r0 = rx8;
    for (int i = 0; i < 40; i++) begin
      pv8 = idx < 3;
      pd8 = arr[idx < 3 ? idx : 0];
      a = pv8 & pr8;
      if (!pr8) sawlow = 1;
      step;
      if (a) idx++;
      run = sv8 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    pv8 = 1'b0;
    chk("t2_run", maxrun, 24);
    chk("t2_ready_drop", sawlow, 1);
    chk("t2_words", rx8 - r0, 3);
    w = 8'h81;
    pd8 = w; pv8 = 1'b1;
    step;
    pv8 = 1'b0;
    c = 0; b = 0; r0 = rx8;
    while (sv8 && c < 30) begin
      sr8 = !(c >= 3 && c < 6);
      chk("t3_bit", sd8, w[b % 8]);
      chk("t3_cnt", dut8.cnt_q, b);
      chk("t3_last", sl8, b == 7);
      if (sr8) b++;
      step;
      c++;
    end
    sr8 = 1'b1;
    chk("t3_cycles", c, 11);
    chk("t3_words", rx8 - r0, 1);
    w = 8'h0F; w2 = 8'hF0; r0 = rx8;
    pd8 = w; pv8 = 1'b1;
    step;
    for (int i = 0; i < 16; i++) begin
      pd8 = w2;
      pv8 = i == 7;
      chk("t4_valid", sv8, 1);
      chk("t4_bit", sd8, i < 8 ? w[i] : w2[i-8]);
      step;
    end
    pv8 = 1'b0;
    chk("t4_idle", sv8, 0);
    chk("t4_words", rx8 - r0, 2);
    pd8 = 8'h55; pv8 = 1'b1;
    step;
    pd8 = 8'hAA;
    step;
    pv8 = 1'b0;
    chk("t5_hold_full", pr8, 0);
    repeat (4) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk("t5_valid", sv8, 0);
    chk("t5_ready", pr8, 1);
    r0 = rx8;
    w = 8'hC3;
    pd8 = w; pv8 = 1'b1;
    step;
    pv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_bit", sd8, w[i]);
      chk("t5_last", sl8, i == 7);
      step;
    end
    repeat (10) step;
    chk("t5_idle", sv8, 0);
    chk("t5_words", rx8 - r0, 1);
    a8 = 0; a5 = 0; r0 = rx8; r5 = rx5; cyc = 0;
    while ((rx8 - r0 < 1000 || rx5 - r5 < 1000) && cyc < 60000) begin
      pv8 = a8 < 1000 && $urandom_range(0, 9) < 7;
      pd8 = 8'($urandom);
      sr8 = $urandom_range(0, 3) != 0;
      pv5 = a5 < 1000 && $urandom_range(0, 9) < 7;
      pd5 = 5'($urandom);
      sr5 = $urandom_range(0, 3) != 0;
      if (pv8 && pr8) a8++;
      if (pv5 && pr5) a5++;
      step;
      cyc++;
    end
    pv8 = 1'b0; pv5 = 1'b0; sr8 = 1'b1; sr5 = 1'b1;
    chk("rand8_words", rx8 - r0, 1000);
    chk("rand5_words", rx5 - r5, 1000);
    chk("rand8_drained", exp8.size(), 0);
    chk("rand5_drained", exp5.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
